// File: rtl/regfile_wb_buffer.sv
// Writeback buffer in front of the 16x16 register file: an in-order FIFO that
// drains one entry per cycle onto the single write port and forwards pending
// (not yet written) values to the two read ports.
module regfile_wb_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     drain_en,
    output logic                     writeReg,
    output logic [ADDR_W-1:0]        dstReg,
    output logic [DATA_W-1:0]        dstData,
    input  logic [ADDR_W-1:0]        srcReg_1,
    input  logic [ADDR_W-1:0]        srcReg_2,
    output logic                     fwd_hit_1,
    output logic [DATA_W-1:0]        fwd_data_1,
    output logic                     fwd_hit_2,
    output logic [DATA_W-1:0]        fwd_data_2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    logic push;
    logic pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    // in_ready comes from registered state only; no path from drain_en.
    assign in_ready = !full;
    assign writeReg = !empty && drain_en;
    assign dstReg   = reg_q[head_q];
    assign dstData  = data_q[head_q];

    assign push = in_valid && in_ready;
    assign pop  = writeReg;

    // Occupancy next-state: push and pop together leave count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers, count and valid bits, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            // push and pop never target the same slot: pop needs !empty, push needs !full
            // and the pointers only coincide when empty or full.
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
        end
    end

    // Entry payload; contents are don't-care while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            reg_q[tail_q]  <= in_reg;
            data_q[tail_q] <= in_data;
        end
    end

    // Forwarding: scan oldest to youngest so the youngest valid match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = head_q;
        fwd_hit_1  = 1'b0;
        fwd_data_1 = '0;
        fwd_hit_2  = 1'b0;
        fwd_data_2 = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (reg_q[idx] == srcReg_1)) begin
                fwd_hit_1  = 1'b1;
                fwd_data_1 = data_q[idx];
            end
            if (valid_q[idx] && (reg_q[idx] == srcReg_2)) begin
                fwd_hit_2  = 1'b1;
                fwd_data_2 = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Self-checking bench for regfile_wb_buffer: a directed vector table followed by
// model-checked sequences for streaming with wrap-around and mid-operation reset.
module tb_regfile_wb_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg;
    logic [15:0] in_data;
    logic        drain_en;
    logic        writeReg;
    logic [3:0]  dstReg;
    logic [15:0] dstData;
    logic [3:0]  srcReg_1;
    logic [3:0]  srcReg_2;
    logic        fwd_hit_1;
    logic [15:0] fwd_data_1;
    logic        fwd_hit_2;
    logic [15:0] fwd_data_2;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (16),
        .ADDR_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .drain_en   (drain_en),
        .writeReg   (writeReg),
        .dstReg     (dstReg),
        .dstData    (dstData),
        .srcReg_1   (srcReg_1),
        .srcReg_2   (srcReg_2),
        .fwd_hit_1  (fwd_hit_1),
        .fwd_data_1 (fwd_data_1),
        .fwd_hit_2  (fwd_hit_2),
        .fwd_data_2 (fwd_data_2),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        bit          rst;
        bit          v;
        logic [3:0]  ireg;
        logic [15:0] idata;
        bit          drain;
        logic [3:0]  s1;
        logic [3:0]  s2;
        bit          wr;
        logic [3:0]  dreg;
        logic [15:0] ddata;
        bit          rdy;
        logic [2:0]  cnt;
        bit          emp;
        bit          ful;
        bit          h1;
        logic [15:0] d1;
        bit          h2;
        logic [15:0] d2;
    } vec_t;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [3:0] ireg,
                         input logic [15:0] idata, input bit dr,
                         input logic [3:0] a1, input logic [3:0] a2);
        rst      = r;
        in_valid = v;
        in_reg   = ireg;
        in_data  = idata;
        drain_en = dr;
        srcReg_1 = a1;
        srcReg_2 = a2;
    endtask

    // One cycle checked against a queue model of the pending writes.
    task automatic step(input bit r, input bit v, input logic [3:0] ireg,
                        input logic [15:0] idata, input bit dr,
                        input logic [3:0] a1, input logic [3:0] a2, output bit acc);
        bit          e_wr;
        bit          e_h1;
        bit          e_h2;
        logic [15:0] e_d1;
        logic [15:0] e_d2;
        drive(r, v, ireg, idata, dr, a1, a2);
        @(negedge clk);
        e_wr = (q.size() > 0) && dr;
        e_h1 = 1'b0;
        e_h2 = 1'b0;
        e_d1 = '0;
        e_d2 = '0;
        foreach (q[i]) begin
            if (q[i].r == a1) begin e_h1 = 1'b1; e_d1 = q[i].d; end
            if (q[i].r == a2) begin e_h2 = 1'b1; e_d2 = q[i].d; end
        end
        chk("m_writeReg", 32'(writeReg), 32'(e_wr));
        if (e_wr) begin
            chk("m_dstReg", 32'(dstReg), 32'(q[0].r));
            chk("m_dstData", 32'(dstData), 32'(q[0].d));
        end
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("m_fwd_hit_1", 32'(fwd_hit_1), 32'(e_h1));
        chk("m_fwd_data_1", 32'(fwd_data_1), 32'(e_d1));
        chk("m_fwd_hit_2", 32'(fwd_hit_2), 32'(e_h2));
        chk("m_fwd_data_2", 32'(fwd_data_2), 32'(e_d2));
        @(posedge clk);
        #1;
        acc = !r && v && (q.size() < DEPTH);
        if (r) begin
            q.delete();
        end else begin
            if (e_wr) void'(q.pop_front());
            if (acc) q.push_back('{r: ireg, d: idata});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[18];
        bit   acc;
        int   k;
        //          chk rst v ireg idata    dr s1 s2 | wr dreg ddata  rdy cnt emp ful h1 d1  h2 d2
        vecs[0]  = '{0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0, 0, 16'h0};
        vecs[1]  = '{1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0, 0, 16'h0};
        // Single push, drained the next cycle, forwarded while pending.
        vecs[2]  = '{1, 0, 1, 3, 16'h00AA, 1, 3, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0, 0, 16'h0};
        vecs[3]  = '{1, 0, 0, 0, 16'h0000, 1, 3, 0, 1, 3, 16'h00AA, 1, 1, 0, 0,
                     1, 16'h00AA, 0, 16'h0};
        vecs[4]  = '{1, 0, 0, 0, 16'h0000, 1, 3, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0, 0, 16'h0};
        // Duplicate register: youngest value forwarded.
        vecs[5]  = '{1, 0, 1, 5, 16'h1111, 0, 5, 7, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0, 0, 16'h0};
        vecs[6]  = '{1, 0, 1, 5, 16'h2222, 0, 5, 7, 0, 0, 16'h0000, 1, 1, 0, 0,
                     1, 16'h1111, 0, 16'h0};
        vecs[7]  = '{1, 0, 1, 7, 16'h3333, 0, 5, 7, 0, 0, 16'h0000, 1, 2, 0, 0,
                     1, 16'h2222, 0, 16'h0};
        vecs[8]  = '{1, 0, 0, 0, 16'h0000, 0, 5, 7, 0, 0, 16'h0000, 1, 3, 0, 0,
                     1, 16'h2222, 1, 16'h3333};
        vecs[9]  = '{1, 0, 0, 0, 16'h0000, 0, 9, 5, 0, 0, 16'h0000, 1, 3, 0, 0,
                     0, 16'h0000, 1, 16'h2222};
        // Fill to full; the extra push while full is dropped.
        vecs[10] = '{1, 0, 1, 1, 16'h0101, 0, 1, 1, 0, 0, 16'h0000, 1, 3, 0, 0,
                     0, 16'h0000, 0, 16'h0};
        vecs[11] = '{1, 0, 1, 2, 16'h0202, 0, 1, 5, 0, 0, 16'h0000, 0, 4, 0, 1,
                     1, 16'h0101, 1, 16'h2222};
        vecs[12] = '{1, 0, 0, 0, 16'h0000, 0, 2, 7, 0, 0, 16'h0000, 0, 4, 0, 1,
                     0, 16'h0000, 1, 16'h3333};
        // Drain in push order; head being written still forwards.
        vecs[13] = '{1, 0, 0, 0, 16'h0000, 1, 5, 7, 1, 5, 16'h1111, 0, 4, 0, 1,
                     1, 16'h2222, 1, 16'h3333};
        vecs[14] = '{1, 0, 0, 0, 16'h0000, 1, 5, 7, 1, 5, 16'h2222, 1, 3, 0, 0,
                     1, 16'h2222, 1, 16'h3333};
        vecs[15] = '{1, 0, 0, 0, 16'h0000, 1, 5, 7, 1, 7, 16'h3333, 1, 2, 0, 0,
                     0, 16'h0000, 1, 16'h3333};
        vecs[16] = '{1, 0, 0, 0, 16'h0000, 1, 7, 1, 1, 1, 16'h0101, 1, 1, 0, 0,
                     0, 16'h0000, 1, 16'h0101};
        vecs[17] = '{1, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0, 0, 16'h0};

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].ireg, vecs[i].idata, vecs[i].drain,
                  vecs[i].s1, vecs[i].s2);
            @(negedge clk);
            if (vecs[i].chk) begin
                chk($sformatf("v%0d_writeReg", i), 32'(writeReg), 32'(vecs[i].wr));
                if (vecs[i].wr) begin
                    chk($sformatf("v%0d_dstReg", i), 32'(dstReg), 32'(vecs[i].dreg));
                    chk($sformatf("v%0d_dstData", i), 32'(dstData), 32'(vecs[i].ddata));
                end
                chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
                chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
                chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
                chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].ful));
                chk($sformatf("v%0d_fwd_hit_1", i), 32'(fwd_hit_1), 32'(vecs[i].h1));
                chk($sformatf("v%0d_fwd_data_1", i), 32'(fwd_data_1), 32'(vecs[i].d1));
                chk($sformatf("v%0d_fwd_hit_2", i), 32'(fwd_hit_2), 32'(vecs[i].h2));
                chk($sformatf("v%0d_fwd_data_2", i), 32'(fwd_data_2), 32'(vecs[i].d2));
            end
            @(posedge clk);
            #1;
        end

        // Streaming: fill, then drain while the producer keeps offering new entries.
        // in_ready is low while full, so count drops to DEPTH-1 on the first drain
        // cycle and then holds as push and pop balance; pointers wrap several times.
        q.delete();
        for (k = 0; k < 4; k++) begin
            step(0, 1, 4'(k % 3), 16'hB000 + 16'(k), 0, 4'(k % 3), 4'((k + 1) % 3), acc);
        end
        k = 4;
        for (int c = 0; c < 14; c++) begin
            step(0, 1, 4'(k % 3), 16'hB000 + 16'(k), 1, 4'(c % 3), 4'((c + 2) % 3), acc);
            if (acc) k++;
        end
        for (int c = 0; c < 8 && q.size() > 0; c++) begin
            step(0, 0, 4'd0, 16'h0, 1, 4'd0, 4'd1, acc);
        end
        chk("stream_pushed", 32'(k >= 2 * DEPTH), 32'd1);

        // Reset mid-operation with a push present: nothing pending survives.
        step(0, 1, 4'd8, 16'hC008, 0, 4'd8, 4'd9, acc);
        step(0, 1, 4'd9, 16'hC009, 0, 4'd8, 4'd9, acc);
        step(0, 1, 4'd10, 16'hC00A, 0, 4'd10, 4'd9, acc);
        step(1, 1, 4'd11, 16'hDEAD, 0, 4'd8, 4'd11, acc);
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 4'd0, 16'h0, 1, 4'd8 + 4'(c), 4'd11, acc);
        end
        @(negedge clk);
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_full", 32'(full), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
